// File: rtl/enigma_pkg.sv
// Shared constants for the Enigma rotor stack: alphabet size, rotor wirings
// (forward and inverse), notches, reflector B, rotor slot assignment and the
// FSM state encoding.
package enigma_pkg;

    localparam logic [4:0] ALPHA = 5'd26;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        STEP = 3'd1,
        FWD  = 3'd2,
        REFL = 3'd3,
        BWD  = 3'd4,
        DONE = 3'd5
    } state_e;

    typedef enum logic [1:0] {
        ROT_I   = 2'd0,
        ROT_II  = 2'd1,
        ROT_III = 2'd2,
        ROT_IV  = 2'd3
    } rotor_e;

    // Index 0 is the entry contact for letter A.
    typedef logic [0:25][4:0] wiring_t;
    typedef wiring_t wiring_tbl_t [0:3];

    // Reduce a value in 0..51 into 0..25.
    function automatic logic [4:0] mod26(input logic [5:0] v);
        if (v >= 6'd26) begin
            mod26 = 5'(v - 6'd26);
        end else begin
            mod26 = v[4:0];
        end
    endfunction

    // Advance a rotor position by one, wrapping Z back to A.
    function automatic logic [4:0] inc26(input logic [4:0] v);
        if (v == 5'd25) begin
            inc26 = 5'd0;
        end else begin
            inc26 = v + 5'd1;
        end
    endfunction

    // Build the return-path table from a forward wiring.
    function automatic wiring_t invert_wiring(input wiring_t w);
        wiring_t r;
        r = '0;
        for (int i = 0; i < 26; i++) begin
            r[w[i]] = 5'(i);
        end
        return r;
    endfunction

    localparam wiring_t WIRING_I = '{
        5'd4, 5'd10, 5'd12, 5'd5, 5'd11, 5'd6, 5'd3, 5'd16, 5'd21, 5'd25, 5'd13, 5'd19, 5'd14,
        5'd22, 5'd24, 5'd7, 5'd23, 5'd20, 5'd18, 5'd15, 5'd0, 5'd8, 5'd1, 5'd17, 5'd2, 5'd9};
    localparam wiring_t WIRING_II = '{
        5'd0, 5'd9, 5'd3, 5'd10, 5'd18, 5'd8, 5'd17, 5'd20, 5'd23, 5'd1, 5'd11, 5'd7, 5'd22,
        5'd19, 5'd12, 5'd2, 5'd16, 5'd6, 5'd25, 5'd13, 5'd15, 5'd24, 5'd5, 5'd21, 5'd14, 5'd4};
    localparam wiring_t WIRING_III = '{
        5'd1, 5'd3, 5'd5, 5'd7, 5'd9, 5'd11, 5'd2, 5'd15, 5'd17, 5'd19, 5'd23, 5'd21, 5'd25,
        5'd13, 5'd24, 5'd4, 5'd8, 5'd22, 5'd6, 5'd0, 5'd10, 5'd12, 5'd20, 5'd18, 5'd16, 5'd14};
    localparam wiring_t WIRING_IV = '{
        5'd4, 5'd18, 5'd14, 5'd21, 5'd15, 5'd25, 5'd9, 5'd0, 5'd24, 5'd16, 5'd20, 5'd8, 5'd17,
        5'd7, 5'd23, 5'd11, 5'd13, 5'd5, 5'd19, 5'd6, 5'd10, 5'd3, 5'd2, 5'd12, 5'd22, 5'd1};
    localparam wiring_t REFLECTOR_B = '{
        5'd24, 5'd17, 5'd20, 5'd7, 5'd16, 5'd18, 5'd11, 5'd3, 5'd15, 5'd23, 5'd13, 5'd6, 5'd14,
        5'd10, 5'd12, 5'd8, 5'd4, 5'd1, 5'd5, 5'd25, 5'd2, 5'd22, 5'd21, 5'd9, 5'd0, 5'd19};

    localparam wiring_tbl_t WIRING_FWD = '{WIRING_I, WIRING_II, WIRING_III, WIRING_IV};
    localparam wiring_tbl_t WIRING_INV = '{invert_wiring(WIRING_I), invert_wiring(WIRING_II),
                                           invert_wiring(WIRING_III), invert_wiring(WIRING_IV)};

    // Turnover letters: I=Q, II=E, III=V, IV=J.
    localparam logic [4:0] NOTCH [0:3] = '{5'd16, 5'd4, 5'd21, 5'd9};

    // Slot k (0 = fastest, rightmost) holds this rotor.
    localparam rotor_e ROTOR_SEL [0:3] = '{ROT_III, ROT_II, ROT_I, ROT_IV};

endpackage

// File: rtl/enigma_rotor_stack_if.sv
// Character stream handshake for the rotor stack: valid/ready on the input
// letter and on the cipher result.
interface enigma_rotor_stack_if;
    logic       in_valid;
    logic [7:0] in_char;
    logic       in_ready;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_char;

    modport master (
        output in_valid, in_char, out_ready,
        input  in_ready, out_valid, out_char
    );

    modport slave (
        input  in_valid, in_char, out_ready,
        output in_ready, out_valid, out_char
    );
endinterface

// File: rtl/enigma_rotor_map.sv
// Single-rotor substitution, purely combinational. Time-shared by the stack
// across all rotor slots in both directions.
module enigma_rotor_map
    import enigma_pkg::*;
(
    input  rotor_e     sel_i,
    input  logic [4:0] pos_i,
    input  logic [4:0] char_i,
    input  logic       inv_i,
    output logic [4:0] char_o
);

    logic [4:0] entry_s;
    logic [4:0] wired_s;

    // Offset into the rotor by its position, pass through the wiring, then undo the offset.
    always_comb begin
        entry_s = mod26({1'b0, char_i} + {1'b0, pos_i});
        if (inv_i) begin
            wired_s = WIRING_INV[sel_i][entry_s];
        end else begin
            wired_s = WIRING_FWD[sel_i][entry_s];
        end
        char_o = mod26({1'b0, wired_s} + 6'd26 - {1'b0, pos_i});
    end

endmodule

// File: rtl/enigma_rotor_stack.sv
// Clocked Enigma core: NUM_ROTORS rotors, odometer stepping, reflector B,
// one rotor per cycle. Define ENIGMA_DOUBLE_STEP_EN to enable the historical
// double-step of middle rotors sitting at their own notch.
module enigma_rotor_stack
    import enigma_pkg::*;
#(
    parameter int NUM_ROTORS = 3
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      load,
    input  logic [5*NUM_ROTORS-1:0]   init_pos,
    output logic [5*NUM_ROTORS-1:0]   positions,
    output logic                      busy,
    enigma_rotor_stack_if.slave       bus
);

    localparam int RI_W = (NUM_ROTORS > 1) ? $clog2(NUM_ROTORS) : 1;
    localparam logic [RI_W-1:0] RI_LAST = RI_W'(NUM_ROTORS - 1);

    state_e                        state_q, state_d;
    logic [NUM_ROTORS-1:0][4:0]    pos_q, pos_d;
    logic [4:0]                    c_q, c_d;
    logic [RI_W-1:0]               ri_q, ri_d;
    logic                          out_valid_q, out_valid_d;
    logic [7:0]                    out_char_q, out_char_d;
    logic                          busy_q, busy_d;

    logic [NUM_ROTORS-1:0]         step_s;
    logic [NUM_ROTORS-1:0][4:0]    load_pos_s;
    logic [4:0]                    map_char_s;

    enigma_rotor_map u_map (
        .sel_i  (ROTOR_SEL[ri_q]),
        .pos_i  (pos_q[ri_q]),
        .char_i (c_q),
        .inv_i  (state_q == BWD),
        .char_o (map_char_s)
    );

    assign bus.in_ready  = (state_q == IDLE) && !load;
    assign bus.out_valid = out_valid_q;
    assign bus.out_char  = out_char_q;
    assign positions     = pos_q;
    assign busy          = busy_q;

    // Decide which rotors advance: carry ripples from rotor 0 through notches.
    always_comb begin : step_logic
        logic carry_v;
        step_s  = '0;
        carry_v = 1'b1;
        for (int k = 0; k < NUM_ROTORS; k++) begin
`ifdef ENIGMA_DOUBLE_STEP_EN
            step_s[k] = carry_v || ((k >= 1) && (k <= NUM_ROTORS - 2) &&
                                    (pos_q[k] == NOTCH[ROTOR_SEL[k]]));
`else
            step_s[k] = carry_v;
`endif
            carry_v = step_s[k] && (pos_q[k] == NOTCH[ROTOR_SEL[k]]);
        end
    end

    // Fold out-of-range start positions back into the alphabet.
    always_comb begin
        load_pos_s = '0;
        for (int k = 0; k < NUM_ROTORS; k++) begin
            load_pos_s[k] = mod26({1'b0, init_pos[5*k +: 5]});
        end
    end

    // Next-state logic for the letter pipeline.
    always_comb begin
        state_d     = state_q;
        pos_d       = pos_q;
        c_d         = c_q;
        ri_d        = ri_q;
        out_valid_d = out_valid_q;
        out_char_d  = out_char_q;
        case (state_q)
            IDLE: begin
                if (load) begin
                    pos_d = load_pos_s;
                end else if (bus.in_valid) begin
                    if (bus.in_char < 8'd26) begin
                        c_d     = bus.in_char[4:0];
                        state_d = STEP;
                    end else begin
                        out_char_d  = bus.in_char;
                        out_valid_d = 1'b1;
                        state_d     = DONE;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            STEP: begin
                for (int k = 0; k < NUM_ROTORS; k++) begin
                    if (step_s[k]) begin
                        pos_d[k] = inc26(pos_q[k]);
                    end else begin
                        pos_d[k] = pos_q[k];
                    end
                end
                ri_d    = '0;
                state_d = FWD;
            end
            FWD: begin
                c_d = map_char_s;
                if (ri_q == RI_LAST) begin
                    state_d = REFL;
                end else begin
                    ri_d = ri_q + RI_W'(1);
                end
            end
            REFL: begin
                c_d     = REFLECTOR_B[c_q];
                ri_d    = RI_LAST;
                state_d = BWD;
            end
            BWD: begin
                c_d = map_char_s;
                if (ri_q == '0) begin
                    out_char_d  = {3'b000, map_char_s};
                    out_valid_d = 1'b1;
                    state_d     = DONE;
                end else begin
                    ri_d = ri_q - RI_W'(1);
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end else begin
                    out_valid_d = 1'b1;
                end
            end
            default: begin
                out_valid_d = 1'b0;
                state_d     = IDLE;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    // State and output registers; reset drops any in-flight letter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            pos_q       <= '0;
            c_q         <= 5'd0;
            ri_q        <= '0;
            out_valid_q <= 1'b0;
            out_char_q  <= 8'd0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            pos_q       <= pos_d;
            c_q         <= c_d;
            ri_q        <= ri_d;
            out_valid_q <= out_valid_d;
            out_char_q  <= out_char_d;
            busy_q      <= busy_d;
        end
    end

endmodule

// File: tb/tb_enigma_rotor_stack.sv
// Directed bench for enigma_rotor_stack (NUM_ROTORS=3) with hand-computed
// expected ciphertext, positions and latencies.
module tb_enigma_rotor_stack;

    logic        clk;
    logic        reset;
    logic        load;
    logic [14:0] init_pos;
    logic [14:0] positions;
    logic        busy;
    int          checks;
    int          errors;
    logic [7:0]  got;
    logic [7:0]  got2;
    logic [14:0] ds_exp [0:3];

    enigma_rotor_stack_if bus_if ();

    enigma_rotor_stack #(.NUM_ROTORS(3)) dut (
        .clk       (clk),
        .reset     (reset),
        .load      (load),
        .init_pos  (init_pos),
        .positions (positions),
        .busy      (busy),
        .bus       (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [14:0] pk(input int r2, input int r1, input int r0);
        return {5'(r2), 5'(r1), 5'(r0)};
    endfunction

    task automatic do_load(input logic [14:0] p);
        load     = 1'b1;
        init_pos = p;
        tick();
        load = 1'b0;
    endtask

    // Send one character, wait for the result, optionally hold backpressure, then accept.
    task automatic send(input string tag, input logic [7:0] ch, input logic chk_char,
                        input logic [7:0] exp_ch, input int exp_lat, input int hold,
                        output logic [7:0] res);
        int n;
        int lat;
        n = 0;
        while (!bus_if.in_ready && n < 20) begin
            tick();
            n++;
        end
        check({tag, "_rdy"}, 32'(bus_if.in_ready), 32'd1);
        bus_if.in_valid = 1'b1;
        bus_if.in_char  = ch;
        tick();
        bus_if.in_valid = 1'b0;
        lat = 1;
        while (!bus_if.out_valid && lat < 40) begin
            tick();
            lat++;
        end
        check({tag, "_vld"}, 32'(bus_if.out_valid), 32'd1);
        check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        res = bus_if.out_char;
        if (chk_char) check({tag, "_chr"}, 32'(bus_if.out_char), 32'(exp_ch));
        for (int i = 0; i < hold; i++) begin
            tick();
            check({tag, "_hold_vld"}, 32'(bus_if.out_valid), 32'd1);
            check({tag, "_hold_chr"}, 32'(bus_if.out_char), 32'(exp_ch));
            check({tag, "_hold_rdy"}, 32'(bus_if.in_ready), 32'd0);
        end
        bus_if.out_ready = 1'b1;
        tick();
        bus_if.out_ready = 1'b0;
        check({tag, "_rel_vld"}, 32'(bus_if.out_valid), 32'd0);
        check({tag, "_rel_busy"}, 32'(busy), 32'd0);
        check({tag, "_rel_rdy"}, 32'(bus_if.in_ready), 32'd1);
    endtask

    initial begin
        logic [7:0] abc_exp [0:4];
        logic [7:0] nl [0:2];
        checks = 0;
        errors = 0;
        reset = 1'b1;
        load = 1'b0;
        init_pos = '0;
        bus_if.in_valid = 1'b0;
        bus_if.in_char = 8'd0;
        bus_if.out_ready = 1'b0;
        abc_exp = '{8'd1, 8'd3, 8'd25, 8'd6, 8'd14};
        nl = '{8'h41, 8'd26, 8'd255};
`ifdef ENIGMA_DOUBLE_STEP_EN
        ds_exp = '{pk(0, 3, 21), pk(0, 4, 22), pk(1, 5, 23), pk(1, 5, 24)};
`else
        ds_exp = '{pk(0, 3, 21), pk(0, 4, 22), pk(0, 4, 23), pk(0, 4, 24)};
`endif

        // Reset values.
        tick();
        tick();
        check("rst_out_valid", 32'(bus_if.out_valid), 32'd0);
        check("rst_out_char", 32'(bus_if.out_char), 32'd0);
        check("rst_positions", 32'(positions), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        reset = 1'b0;
        tick();
        check("rst_in_ready", 32'(bus_if.in_ready), 32'd1);

        // Five A's from AAA give BDZGO.
        do_load(pk(0, 0, 0));
        for (int i = 0; i < 5; i++) begin
            send($sformatf("aaa%0d", i), 8'd0, 1'b1, abc_exp[i], 9, 0, got);
        end
        check("aaa_pos", 32'(positions), 32'(pk(0, 0, 5)));

        // Notch carry (and double step when enabled) from ADU.
        do_load(pk(0, 3, 20));
        for (int i = 0; i < 4; i++) begin
            send($sformatf("ds%0d", i), 8'd0, 1'b0, 8'd0, 9, 0, got);
            check($sformatf("ds%0d_pos", i), 32'(positions), 32'(ds_exp[i]));
        end

        // Non-letters pass through in one cycle without stepping.
        for (int i = 0; i < 3; i++) begin
            send($sformatf("nl%0d", i), nl[i], 1'b1, nl[i], 1, 0, got);
            check($sformatf("nl%0d_pos", i), 32'(positions), 32'(ds_exp[3]));
        end

        // Backpressure: result held stable for 10 cycles.
        do_load(pk(0, 0, 0));
        send("bp", 8'd0, 1'b1, 8'd1, 9, 10, got);

        // Reset in the middle of a letter.
        do_load(pk(0, 0, 0));
        bus_if.in_valid = 1'b1;
        bus_if.in_char = 8'd0;
        tick();
        bus_if.in_valid = 1'b0;
        tick();
        check("mid_busy_pre", 32'(busy), 32'd1);
        check("mid_pos_stepped", 32'(positions), 32'(pk(0, 0, 1)));
        tick();
        tick();
        reset = 1'b1;
        #1;
        check("mid_out_valid", 32'(bus_if.out_valid), 32'd0);
        check("mid_positions", 32'(positions), 32'd0);
        check("mid_busy", 32'(busy), 32'd0);
        tick();
        reset = 1'b0;
        tick();
        send("post_rst", 8'd0, 1'b1, 8'd1, 9, 0, got);

        // Reciprocity: decrypting with the same start gives the letter back.
        do_load(pk(7, 2, 11));
        send("recip_a", 8'd7, 1'b0, 8'd0, 9, 0, got);
        check("recip_noself", 32'(got != 8'd7), 32'd1);
        check("recip_range", 32'(got < 8'd26), 32'd1);
        do_load(pk(7, 2, 11));
        send("recip_b", got, 1'b1, 8'd7, 9, 0, got2);

        // load wins over in_valid; out-of-range fields fold by 26.
        load = 1'b1;
        init_pos = pk(30, 26, 31);
        bus_if.in_valid = 1'b1;
        bus_if.in_char = 8'd3;
        #1;
        check("ld_in_ready", 32'(bus_if.in_ready), 32'd0);
        tick();
        load = 1'b0;
        bus_if.in_valid = 1'b0;
        check("ld_busy", 32'(busy), 32'd0);
        check("ld_positions", 32'(positions), 32'(pk(4, 0, 5)));
        tick();
        check("ld_no_out", 32'(bus_if.out_valid), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
